prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 24 ++
 rtl/sync_edge.sv | 29 ++
 rtl/prog_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared loader/CPU definitions: frame header, memory depth, loader state encoding.
// The CPU side imports the same package so its program-memory width matches.
package prog_loader_pkg;

  localparam int         PL_MEM_DEPTH = 32;
  localparam logic [7:0] PL_MAGIC     = 8'hA5;
  localparam int         PL_ADDR_W    = 5;
  localparam int         PL_LEN_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } pl_state_e;

  // Running frame checksum is a plain byte-wise XOR.
  function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous strobe, plus a rising-edge detector
// on the synchronised level.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchroniser chain and one-cycle history of the synchronised level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/prog_loader.sv
// Host byte-stream program loader: receives MAGIC, length, data and XOR checksum,
// writes the data into CPU program memory and releases the CPU on a good frame.
import prog_loader_pkg::*;

module prog_loader #(
  parameter int         MEM_DEPTH = PL_MEM_DEPTH,
  parameter logic [7:0] MAGIC     = PL_MAGIC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           host_data,
  input  logic                 host_stb,
  input  logic                 clr,
  output logic                 mem_we,
  output logic [PL_ADDR_W-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 cpu_run,
  output logic                 busy,
  output logic                 err
);

  logic [7:0]          data_meta_r;
  logic [7:0]          data_sync_r;
  logic                stb_rise_s;
  pl_state_e           state_r;
  logic [PL_LEN_W-1:0] len_r;
  logic [PL_ADDR_W-1:0] cnt_r;
  logic [7:0]          csum_r;
  logic                len_ok_s;
  logic                last_s;

  sync_edge u_stb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (host_stb),
    .rise  (stb_rise_s)
  );

  // Data bus synchroniser; the host holds data stable around its strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_meta_r <= 8'h00;
      data_sync_r <= 8'h00;
    end else begin
      data_meta_r <= host_data;
      data_sync_r <= data_meta_r;
    end
  end

  assign len_ok_s = (data_sync_r != 8'h00) && ({24'd0, data_sync_r} <= MEM_DEPTH);
  assign last_s   = ({1'b0, cnt_r} == (len_r - 6'd1));

  // Frame FSM with registered status and memory-write outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      len_r     <= 6'd0;
      cnt_r     <= 5'd0;
      csum_r    <= 8'h00;
      mem_we    <= 1'b0;
      mem_addr  <= 5'd0;
      mem_wdata <= 8'h00;
      cpu_run   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (clr) begin
        // Abort wins over a byte accepted in the same cycle.
        state_r <= ST_IDLE;
        cnt_r   <= 5'd0;
        csum_r  <= 8'h00;
        cpu_run <= 1'b0;
        busy    <= 1'b0;
        err     <= 1'b0;
      end else if (stb_rise_s) begin
        case (state_r)
          ST_IDLE: begin
            if (data_sync_r == MAGIC) begin
              state_r <= ST_LEN;
              busy    <= 1'b1;
            end
          end
          ST_LEN: begin
            if (len_ok_s) begin
              len_r   <= data_sync_r[PL_LEN_W-1:0];
              cnt_r   <= 5'd0;
              csum_r  <= 8'h00;
              state_r <= ST_DATA;
            end else begin
              state_r <= ST_ERR;
              busy    <= 1'b0;
              err     <= 1'b1;
            end
          end
          ST_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt_r;
            mem_wdata <= data_sync_r;
            csum_r    <= csum_next(csum_r, data_sync_r);
            if (last_s) begin
              state_r <= ST_CSUM;
            end else begin
              cnt_r <= cnt_r + 5'd1;
            end
          end
          ST_CSUM: begin
            busy <= 1'b0;
            if (data_sync_r == csum_r) begin
              state_r <= ST_RUN;
              cpu_run <= 1'b1;
            end else begin
              state_r <= ST_ERR;
              err     <= 1'b1;
            end
          end
          ST_RUN: begin
            state_r <= ST_RUN;
          end
          ST_ERR: begin
            state_r <= ST_ERR;
          end
          default: begin
            state_r <= ST_IDLE;
            cpu_run <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
